inst_fetch: RTL and testbench

Instruction fetch unit that serves the program counter produced by the PC register. It looks up `pc` in a direct-mapped instruction cache. On a miss it assembles the 32-bit instruction from four byte reads over the byte-wide memory arbiter port. It raises the fetch stall request that freezes the PC, and delivers `inst`/`inst_pc` to the IF/ID stage. It also aborts in-flight fetches when a jump is resolved.

---
 rtl/inst_fetch_pkg.sv | 34 +++
 rtl/inst_fetch_icache.sv | 55 +++++
 rtl/inst_fetch.sv | 179 +++++++++++++++++
 tb/tb_inst_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit
// and its direct-mapped instruction cache.
package inst_fetch_pkg;

  localparam int          IDX_W_DEF = 7;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  function automatic inst_t put_byte(
    input inst_t      w,
    input logic [1:0] lane,
    input logic [7:0] b
  );
    inst_t r;
    r = w;
    unique case (lane)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      2'd3: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache:
// combinational lookup, synchronous fill, reset clears valid bits.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_rd_wa,
  output logic        o_hit,
  output logic [31:0] o_rdata,
  input  logic        i_we,
  input  logic [29:0] i_wr_wa,
  input  logic [31:0] i_wdata
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int N     = 1 << IDX_W;

  logic [N-1:0]     r_valid;
  logic [TAG_W-1:0] r_tag  [N];
  logic [31:0]      r_data [N];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;

  assign w_rd_idx = i_rd_wa[IDX_W-1:0];
  assign w_rd_tag = i_rd_wa[29:IDX_W];
  assign w_wr_idx = i_wr_wa[IDX_W-1:0];
  assign w_wr_tag = i_wr_wa[29:IDX_W];

  assign o_hit   = r_valid[w_rd_idx]
                && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rdata = r_data[w_rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_wr_idx] <= TRUE;
    end
  end

  // tag/data arrays need no reset; valid bits gate them
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wdata;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: cache lookup, byte-serial miss fill,
// stall request and IF/ID output registers.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        jump_res,
  input  logic        stall_hold,
  output logic        if_stall_req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_din,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_e r_state;
  fetch_state_e w_state_n;

  inst_addr_t r_fetch_pc;
  inst_t      r_buf;
  inst_t      r_inst;
  inst_addr_t r_inst_pc;
  logic       r_inst_valid;
  logic [2:0] r_req_cnt;
  logic [1:0] r_rcv_cnt;
  logic       r_rcv_pend;
  logic       r_done;

  logic       w_hit;
  inst_t      w_cdata;
  logic       w_idle_miss;
  logic       w_cap3;
  logic       w_fill_we;
  logic       w_req;
  inst_addr_t w_addr;
  inst_t      w_word;

  icache_dm #(
    .IDX_W (IDX_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .i_rd_wa (pc[31:2]),
    .o_hit   (w_hit),
    .o_rdata (w_cdata),
    .i_we    (w_fill_we),
    .i_wr_wa (r_fetch_pc[31:2]),
    .i_wdata (w_word)
  );

  assign w_idle_miss = (r_state == S_IDLE) && !w_hit;
  assign w_cap3      = (r_state == S_FETCH)
                    && r_rcv_pend
                    && (r_rcv_cnt == 2'd3);
  assign w_word      = {mem_din, r_buf[23:0]};
  // a fill landing with a jump still updates the cache
  assign w_fill_we   = rst && w_cap3;

  assign if_stall_req = (r_state == S_FETCH)
                     || w_idle_miss
                     || stall_hold;

  always_comb begin
    w_req  = FALSE;
    w_addr = ZERO_WORD;
    if (rst && !jump_res) begin
      if (r_state == S_IDLE) begin
        if (!stall_hold && !w_hit) begin
          w_req  = TRUE;
          w_addr = pc;
        end
      end else if (r_req_cnt < 3'd4) begin
        w_req  = TRUE;
        w_addr = r_fetch_pc + {29'd0, r_req_cnt};
      end
    end
  end

  assign mem_req  = w_req;
  assign mem_addr = w_addr;

  always_comb begin
    w_state_n = r_state;
    priority case (1'b1)
      jump_res: begin
        w_state_n = S_IDLE;
      end
      (r_state == S_IDLE): begin
        if (!stall_hold && !w_hit) begin
          w_state_n = S_FETCH;
        end
      end
      default: begin
        if (!stall_hold && (w_cap3 || r_done)) begin
          w_state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc   <= ZERO_WORD;
      r_buf        <= ZERO_WORD;
      r_inst       <= ZERO_WORD;
      r_inst_pc    <= ZERO_WORD;
      r_inst_valid <= FALSE;
      r_req_cnt    <= 3'd0;
      r_rcv_cnt    <= 2'd0;
      r_rcv_pend   <= FALSE;
      r_done       <= FALSE;
    end else begin
      r_rcv_pend <= w_req && mem_rdy;
      if (jump_res) begin
        r_req_cnt    <= 3'd0;
        r_rcv_cnt    <= 2'd0;
        r_done       <= FALSE;
        r_inst_valid <= FALSE;
      end else if (r_state == S_IDLE) begin
        if (!stall_hold) begin
          if (w_hit) begin
            r_inst       <= w_cdata;
            r_inst_pc    <= pc;
            r_inst_valid <= TRUE;
          end else begin
            r_fetch_pc   <= pc;
            r_req_cnt    <= mem_rdy ? 3'd1 : 3'd0;
            r_rcv_cnt    <= 2'd0;
            r_done       <= FALSE;
            r_inst_valid <= FALSE;
          end
        end
      end else begin
        if (w_req && mem_rdy) begin
          r_req_cnt <= r_req_cnt + 3'd1;
        end
        if (r_rcv_pend) begin
          r_buf     <= put_byte(r_buf, r_rcv_cnt, mem_din);
          r_rcv_cnt <= r_rcv_cnt + 2'd1;
        end
        // completed word parks in r_buf until IF/ID frees up
        if (!stall_hold) begin
          if (w_cap3) begin
            r_inst       <= w_word;
            r_inst_pc    <= r_fetch_pc;
            r_inst_valid <= TRUE;
          end else if (r_done) begin
            r_inst       <= r_buf;
            r_inst_pc    <= r_fetch_pc;
            r_inst_valid <= TRUE;
          end
          r_done <= FALSE;
        end else if (w_cap3) begin
          r_done <= TRUE;
        end
      end
    end
  end

  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a byte-wide memory model
// that answers one cycle after each accepted request.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        jump_res;
  logic        stall_hold;
  logic        if_stall_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rdy;
  logic [7:0]  mem_din;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic [7:0] mem [1024];

  int n_run;
  int n_fail;

  inst_fetch #(
    .IDX_W (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .jump_res     (jump_res),
    .stall_hold   (stall_hold),
    .if_stall_req (if_stall_req),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdy      (mem_rdy),
    .mem_din      (mem_din),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // non-accepted cycles return junk so duplicated bytes show up
  always @(posedge clk) begin
    if (mem_req && mem_rdy) mem_din <= mem[mem_addr[9:0]];
    else mem_din <= 8'hEE;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h000] = 8'h13; mem[10'h001] = 8'h05;
    mem[10'h002] = 8'h00; mem[10'h003] = 8'h00;
    mem[10'h040] = 8'h37; mem[10'h041] = 8'h45;
    mem[10'h042] = 8'h23; mem[10'h043] = 8'h01;
    mem[10'h080] = 8'h13; mem[10'h081] = 8'h01;
    mem[10'h082] = 8'h01; mem[10'h083] = 8'hFF;
    mem[10'h100] = 8'h93; mem[10'h101] = 8'h00;
    mem[10'h102] = 8'h10; mem[10'h103] = 8'h00;
    mem[10'h204] = 8'hB3; mem[10'h205] = 8'h80;
    mem[10'h206] = 8'h20; mem[10'h207] = 8'h00;
    mem[10'h300] = 8'h67; mem[10'h301] = 8'h80;
    mem[10'h302] = 8'h00; mem[10'h303] = 8'h00;
    mem[10'h3FC] = 8'h6F; mem[10'h3FD] = 8'h00;
    mem[10'h3FE] = 8'h00; mem[10'h3FF] = 8'h00;
  end

  initial begin
    n_run      = 0;
    n_fail     = 0;
    rst        = 1'b0;
    pc         = 32'h0;
    jump_res   = 1'b0;
    stall_hold = 1'b0;
    mem_rdy    = 1'b1;

    // reset state
    nxt(); nxt(); mid();
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_stall", 32'(if_stall_req), 32'h1);

    // cold miss at 0x0
    nxt(); rst = 1'b1; pc = 32'h0; mid();
    chk("cold_req0", 32'(mem_req), 32'h1);
    chk("cold_addr0", mem_addr, 32'h0);
    chk("cold_stall0", 32'(if_stall_req), 32'h1);
    for (int i = 1; i < 4; i++) begin
      nxt(); mid();
      chk("cold_addr", mem_addr, 32'(i));
      chk("cold_req", 32'(mem_req), 32'h1);
    end
    nxt(); mid();
    chk("cold_c4_req", 32'(mem_req), 32'h0);
    chk("cold_c4_valid", 32'(inst_valid), 32'h0);
    nxt(); mid();
    chk("cold_valid", 32'(inst_valid), 32'h1);
    chk("cold_inst", inst, 32'h0000_0513);
    chk("cold_pc", inst_pc, 32'h0);
    // same pc now hits
    chk("hit_req", 32'(mem_req), 32'h0);
    chk("hit_stall", 32'(if_stall_req), 32'h0);

    // hit registers; new miss at 0x40 with mem_rdy gaps
    nxt(); pc = 32'h40; mid();
    chk("hit_valid", 32'(inst_valid), 32'h1);
    chk("hit_inst", inst, 32'h0000_0513);
    chk("gap_addr0", mem_addr, 32'h40);
    nxt(); mem_rdy = 1'b0; mid();
    chk("gap_addr1", mem_addr, 32'h41);
    chk("gap_valid1", 32'(inst_valid), 32'h0);
    nxt(); mid();
    chk("gap_addr2", mem_addr, 32'h41);
    nxt(); mem_rdy = 1'b1; mid();
    chk("gap_addr3", mem_addr, 32'h41);
    nxt(); mid();
    chk("gap_addr4", mem_addr, 32'h42);
    nxt(); mid();
    chk("gap_addr5", mem_addr, 32'h43);
    nxt(); mid();
    chk("gap_valid6", 32'(inst_valid), 32'h0);
    // cycle 7: result; also start miss at 0x80
    nxt(); pc = 32'h80; mid();
    chk("gap_valid7", 32'(inst_valid), 32'h1);
    chk("gap_inst", inst, 32'h0123_4537);
    chk("gap_pc", inst_pc, 32'h40);
    chk("jmp_addr0", mem_addr, 32'h80);

    // jump while rcv_cnt==2, redirect to 0x100
    nxt(); mid();
    chk("jmp_addr1", mem_addr, 32'h81);
    nxt(); mid();
    chk("jmp_addr2", mem_addr, 32'h82);
    nxt(); jump_res = 1'b1; pc = 32'h100; mid();
    chk("jmp_noreq", 32'(mem_req), 32'h0);
    nxt(); jump_res = 1'b0; mid();
    chk("jmp_valid", 32'(inst_valid), 32'h0);
    chk("jmp_newreq", 32'(mem_req), 32'h1);
    chk("jmp_newaddr", mem_addr, 32'h100);
    nxt(); nxt(); nxt(); mid();
    chk("jmp_addr3", mem_addr, 32'h103);
    nxt(); mid();
    chk("jmp_c4_valid", 32'(inst_valid), 32'h0);
    // result, then miss at 0x204 for stall test
    nxt(); pc = 32'h204; mid();
    chk("jmp_res_valid", 32'(inst_valid), 32'h1);
    chk("jmp_res_inst", inst, 32'h0010_0093);
    chk("jmp_res_pc", inst_pc, 32'h100);
    chk("stl_addr0", mem_addr, 32'h204);

    // stall_hold across completion
    nxt(); nxt(); nxt(); stall_hold = 1'b1; mid();
    chk("stl_addr3", mem_addr, 32'h207);
    nxt(); mid();
    nxt(); mid();
    chk("stl_valid5", 32'(inst_valid), 32'h0);
    chk("stl_inst5", inst, 32'h0010_0093);
    chk("stl_pc5", inst_pc, 32'h100);
    chk("stl_stall5", 32'(if_stall_req), 32'h1);
    chk("stl_req5", 32'(mem_req), 32'h0);
    nxt(); mid();
    chk("stl_valid6", 32'(inst_valid), 32'h0);
    nxt(); stall_hold = 1'b0; mid();
    chk("stl_valid7", 32'(inst_valid), 32'h0);
    chk("stl_stall7", 32'(if_stall_req), 32'h1);
    nxt(); mid();
    chk("stl_valid8", 32'(inst_valid), 32'h1);
    chk("stl_inst8", inst, 32'h0020_80B3);
    chk("stl_pc8", inst_pc, 32'h204);
    chk("stl_hit8", 32'(if_stall_req), 32'h0);

    // wrap-around at top of address space
    nxt(); pc = 32'hFFFF_FFFC; mid();
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    for (int i = 1; i < 4; i++) begin
      nxt(); mid();
      chk("wrap_addr", mem_addr, 32'hFFFF_FFFC + 32'(i));
    end
    nxt(); nxt(); mid();
    chk("wrap_valid", 32'(inst_valid), 32'h1);
    chk("wrap_inst", inst, 32'h0000_006F);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // reset mid-fetch
    nxt(); pc = 32'h300; mid();
    chk("rmf_addr0", mem_addr, 32'h300);
    nxt(); nxt(); rst = 1'b0; mid();
    chk("rmf_req", 32'(mem_req), 32'h0);
    chk("rmf_addr", mem_addr, 32'h0);
    nxt(); mid();
    chk("rmf_valid", 32'(inst_valid), 32'h0);
    chk("rmf_inst", inst, 32'h0);
    chk("rmf_pc", inst_pc, 32'h0);
    nxt(); rst = 1'b1; mid();
    chk("rmf_miss_req", 32'(mem_req), 32'h1);
    chk("rmf_miss_addr", mem_addr, 32'h300);
    chk("rmf_miss_stall", 32'(if_stall_req), 32'h1);
    nxt(); nxt(); nxt(); nxt(); nxt(); mid();
    chk("rmf_valid5", 32'(inst_valid), 32'h1);
    chk("rmf_inst5", inst, 32'h0000_8067);
    chk("rmf_pc5", inst_pc, 32'h300);

    // 0x0 was cached before reset; must miss now
    nxt(); pc = 32'h0; mid();
    chk("clr_req", 32'(mem_req), 32'h1);
    chk("clr_addr", mem_addr, 32'h0);
    chk("clr_stall", 32'(if_stall_req), 32'h1);
    nxt(); nxt(); nxt(); nxt(); nxt(); mid();
    chk("clr_inst", inst, 32'h0000_0513);
    chk("clr_valid", 32'(inst_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
